// File: rtl/multicycle_mips_core_if.sv
// Shared instruction/data memory port. The request side is registered in the core;
// ready completes the pending request on the same rising edge.
interface multicycle_mips_core_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output req, we, addr, wdata, input rdata, ready);
  modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/multicycle_mips_core.sv
// Multicycle MIPS-I subset core with folded control FSM, one shared memory port,
// memory-mapped GPIO and a sticky trap on illegal or misaligned operations.
module multicycle_mips_core #(
  parameter logic [31:0] RESET_PC      = 32'h0040_0000,
  parameter int          GPIO_WIDTH    = 8,
  parameter logic [31:0] GPIO_IN_ADDR  = 32'hFFFF_FFF0,
  parameter logic [31:0] GPIO_OUT_ADDR = 32'hFFFF_FFF4
)(
  input  logic                   clk,
  input  logic                   reset,
  multicycle_mips_core_if.master mem,
  input  logic [GPIO_WIDTH-1:0]  gpio_i,
  output logic [GPIO_WIDTH-1:0]  gpio_o,
  output logic [31:0]            pc_o,
  output logic                   err
);
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04,
                         OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;

  typedef enum logic [3:0] {
    S_START, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_TRAP
  } state_e;

  state_e                state, next_state;
  logic [31:0]           pc, ir, a, b, alu_out, mdr, tgt;
  logic [31:0]           rf [32];
  logic                  is_gpio;
  logic [GPIO_WIDTH-1:0] gpio_s1, gpio_s2;
  logic                  req_q, we_q;
  logic [31:0]           addr_q, wdata_q;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] simm, ea, alu_r, pc_next, rf_wdata, iss_addr;
  logic [4:0]  rf_waddr;
  logic        r_ok, mem_done, gpio_hit, rf_we, issue, iss_we;
  logic        unused_shamt;

  assign op           = ir[31:26];
  assign rs           = ir[25:21];
  assign rt           = ir[20:16];
  assign rd           = ir[15:11];
  assign funct        = ir[5:0];
  assign unused_shamt = ^ir[10:6];
  assign simm         = {{16{ir[15]}}, ir[15:0]};
  assign ea           = a + simm;
  assign mem_done     = req_q & mem.ready;
  assign gpio_hit     = (op == OP_LW) ? (ea == GPIO_IN_ADDR) : (ea == GPIO_OUT_ADDR);
  assign r_ok         = (op == OP_R) && (funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});

  assign mem.req   = req_q;
  assign mem.we    = we_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;
  assign pc_o      = pc;
  assign err       = (state == S_TRAP);

  always_comb begin
    case (funct)
      6'h20:   alu_r = a + b;
      6'h22:   alu_r = a - b;
      6'h24:   alu_r = a & b;
      6'h25:   alu_r = a | b;
      6'h2A:   alu_r = {31'd0, $signed(a) < $signed(b)};
      default: alu_r = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= S_START;
    else        state <= next_state;

  always_comb begin
    next_state = state;
    case (state)
      S_START:  next_state = S_FETCH;
      S_FETCH:  if (mem_done) next_state = S_DECODE;
      S_DECODE: begin
        if (r_ok)                              next_state = S_EXEC_R;
        else if (op == OP_ADDI)                next_state = S_EXEC_I;
        else if (op == OP_LW || op == OP_SW)   next_state = S_MEM_ADDR;
        else if (op == OP_BEQ)                 next_state = S_BRANCH;
        else if (op == OP_J)                   next_state = S_JUMP;
        else                                   next_state = S_TRAP;
      end
      S_EXEC_R, S_EXEC_I: next_state = S_ALU_WB;
      S_MEM_ADDR: begin
        if (ea[1:0] != 2'b00)  next_state = S_TRAP;
        else if (op == OP_LW)  next_state = S_MEM_RD;
        else                   next_state = S_MEM_WR;
      end
      S_MEM_RD: if (is_gpio || mem_done) next_state = S_MEM_WB;
      S_MEM_WR: if (is_gpio || mem_done) next_state = S_FETCH;
      S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: next_state = S_FETCH;
      S_TRAP:   next_state = S_TRAP;
      default:  next_state = S_TRAP;
    endcase
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rd;
    rf_wdata = alu_out;
    pc_next  = pc;
    case (state)
      S_FETCH:  if (mem_done) pc_next = pc + 32'd4;
      S_ALU_WB: begin
        rf_we = 1'b1;
        if (op != OP_R) rf_waddr = rt;
      end
      S_MEM_WB: begin
        rf_we    = 1'b1;
        rf_waddr = rt;
        rf_wdata = mdr;
      end
      S_BRANCH: if (a == b) pc_next = tgt;
      S_JUMP:   pc_next = {pc[31:28], ir[25:0], 2'b00};
      default: ;
    endcase
    // Requests launch only on entry to a memory state; GPIO accesses never touch the bus.
    issue    = (next_state != state) &&
               ((next_state == S_FETCH) ||
                ((next_state inside {S_MEM_RD, S_MEM_WR}) && !gpio_hit));
    iss_we   = (next_state == S_MEM_WR);
    iss_addr = (next_state == S_FETCH) ? pc_next : ea;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_s1 <= '0;
      gpio_s2 <= '0;
    end else begin
      gpio_s1 <= gpio_i;
      gpio_s2 <= gpio_s1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      tgt     <= '0;
      is_gpio <= 1'b0;
      gpio_o  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else begin
      pc <= pc_next;
      if (issue) begin
        req_q   <= 1'b1;
        we_q    <= iss_we;
        addr_q  <= iss_addr;
        wdata_q <= b;
      end else if (mem_done) begin
        req_q <= 1'b0;
      end
      if (rf_we && rf_waddr != 5'd0) rf[rf_waddr] <= rf_wdata;
      case (state)
        S_FETCH:    if (mem_done) ir <= mem.rdata;
        S_DECODE: begin
          a   <= rf[rs];
          b   <= rf[rt];
          tgt <= pc + {simm[29:0], 2'b00};
        end
        S_EXEC_R:   alu_out <= alu_r;
        S_EXEC_I:   alu_out <= a + simm;
        S_MEM_ADDR: is_gpio <= gpio_hit;
        S_MEM_RD: begin
          if (is_gpio)       mdr <= 32'(gpio_s2);
          else if (mem_done) mdr <= mem.rdata;
        end
        S_MEM_WR:   if (is_gpio) gpio_o <= b[GPIO_WIDTH-1:0];
        default: ;
      endcase
    end
  end
endmodule
